// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
//============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing a single FIFO write port between
//               NUM_REQ valid/ready producers. One owner at a time is granted
//               for a burst of up to BURST_MAX beats. fifo_full stalls the
//               owner without releasing the grant.
// Ports       : clk        - rising-edge clock
//               rstN       - synchronous reset, active-low
//               req_valid  - per-requester data valid
//               req_data   - requester i data at [i*DATA_W +: DATA_W]
//               req_ready  - per-requester accept
//               fifo_full  - FIFO full flag
//               write_en   - FIFO write strobe
//               write_data - FIFO write data (owner's slice)
//               grant_id   - current owner
//               busy       - high while a grant is held
// Revision    : 1.0 - initial release
//============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int BURST_MAX = 4,
    localparam int c_IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      write_en,
    output logic [DATA_W-1:0]         write_data,
    output logic [c_IDW-1:0]          grant_id,
    output logic                      busy
);

    localparam int c_CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BURST_MAX - 1);
    localparam logic [c_IDW-1:0]   c_LAST_REQ  = c_IDW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDW-1:0]     r_owner;
    logic [c_IDW-1:0]     w_owner_next;
    logic [c_IDW-1:0]     r_last_owner;
    logic [c_IDW-1:0]     w_last_owner_next;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic [c_CNT_W-1:0]   w_beat_cnt_next;

    logic                 w_any_found;
    logic [c_IDW-1:0]     w_any_idx;
    logic                 w_hi_found;
    logic [c_IDW-1:0]     w_hi_idx;
    logic [c_IDW-1:0]     w_pick_idx;
    logic                 w_owner_valid;
    logic [DATA_W-1:0]    w_owner_data;
    logic                 w_granted;
    logic                 w_active;

    // Round-robin pick: the lowest valid index above last_owner wins; if
    // there is none, wrap around to the lowest valid index overall. The
    // descending scan leaves the lowest matching index in each candidate.
    always_comb begin : p_pick
        w_any_found = 1'b0;
        w_any_idx   = '0;
        w_hi_found  = 1'b0;
        w_hi_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any_found = 1'b1;
                w_any_idx   = c_IDW'(i);
                if (i > int'(r_last_owner)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_IDW'(i);
                end
            end
        end
        w_pick_idx = w_hi_found ? w_hi_idx : w_any_idx;
    end

    // Owner's valid and data slice.
    always_comb begin : p_owner_mux
        w_owner_valid = 1'b0;
        w_owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == c_IDW'(i)) begin
                w_owner_valid = req_valid[i];
                w_owner_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Outputs are forced inactive while reset is asserted, before the
    // registers have been cleared by the next edge.
    assign w_granted  = rstN && (r_state == S_GRANT);
    assign w_active   = w_granted && !fifo_full;
    assign write_en   = w_active && w_owner_valid;
    assign write_data = w_owner_data;
    assign grant_id   = r_owner;
    assign busy       = w_granted;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = w_active && (r_owner == c_IDW'(g));
    end

    // Next-state logic.
    always_comb begin : p_next
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_beat_cnt_next   = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_found) begin
                    w_state_next    = S_GRANT;
                    w_owner_next    = w_pick_idx;
                    w_beat_cnt_next = '0;
                end
            end
            S_GRANT: begin
                if (!w_owner_valid) begin
                    // Owner withdrew: release without writing.
                    w_state_next      = S_IDLE;
                    w_last_owner_next = r_owner;
                end else if (write_en) begin
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_state_next      = S_IDLE;
                        w_last_owner_next = r_owner;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + 1'b1;
                    end
                end
                // Otherwise fifo_full stalls: hold everything, keep grant.
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : p_regs
        if (!rstN) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_LAST_REQ;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_beat_cnt   <= w_beat_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter
//               (NUM_REQ=4, DATA_W=4, BURST_MAX=4). Producers are simple
//               per-requester data lists popped on accepted handshakes;
//               expected write traces are hand-computed constants.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 4;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        write_en;
    logic [3:0]  write_data;
    logic [1:0]  grant_id;
    logic        busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) u_dut (
        .clk        (clk),
        .rstN       (rstN),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .write_en   (write_en),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc;
    int nlog;

    logic [3:0] src [4][16];
    int head [4];
    int len  [4];

    int tr_we   [64];
    int tr_id   [64];
    int tr_busy [64];
    int tr_rdy  [64];
    int log_id  [64];
    int log_data[64];

    int e3_id [21] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0, 1};
    int e3_d  [21] = '{1,2,3,4, 9,10,11,12, 14,15,0,1, 2,3,4,5, 5,6,7,8, 13};
    int e5_id [7]  = '{0,0,3,3,3,3,3};
    int e5_d  [7]  = '{1,2,7,8,9,10,11};
    int e6_id [8]  = '{2,2,0,0,0,0,2,2};
    int e6_d  [8]  = '{1,2,8,9,10,11,3,4};

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle/index context in tag)", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < len[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*4 +: 4] = src[i][head[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*4 +: 4] = 4'h0;
            end
        end
    endtask

    task automatic push(input int r, input int d);
        src[r][len[r]] = 4'(d);
        len[r]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
    endtask

    // One clock: sample at the falling edge, then apply accepted pops just
    // after the rising edge.
    task automatic step();
        logic [3:0] xfer;
        @(negedge clk);
        if (cyc < 64) begin
            tr_we[cyc]   = int'(write_en);
            tr_id[cyc]   = int'(grant_id);
            tr_busy[cyc] = int'(busy);
            tr_rdy[cyc]  = int'(req_ready);
        end
        if (write_en && nlog < 64) begin
            log_id[nlog]   = int'(grant_id);
            log_data[nlog] = int'(write_data);
            nlog++;
        end
        xfer = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (xfer[i]) head[i]++;
        end
        drive_inputs();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        clear_queues();
        drive_inputs();
        fifo_full = 1'b0;
        rstN = 1'b0;
        run(2);
        rstN = 1'b1;
        cyc  = 0;
        nlog = 0;
    endtask

    task automatic check_we(input string tag, input int n, input logic [31:0] exp);
        for (int c = 0; c < n; c++) begin
            check_val($sformatf("%s_we_c%0d", tag, c), tr_we[c], int'(exp[c]));
        end
    endtask

    initial begin
        rstN      = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        cyc  = 0;
        nlog = 0;

        // Test 1: reset held with every requester valid.
        clear_queues();
        for (int i = 0; i < 4; i++) push(i, i + 1);
        drive_inputs();
        @(posedge clk);
        #1;
        run(3);
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("t1_we_c%0d", c),   tr_we[c],   0);
            check_val($sformatf("t1_rdy_c%0d", c),  tr_rdy[c],  0);
            check_val($sformatf("t1_busy_c%0d", c), tr_busy[c], 0);
            check_val($sformatf("t1_id_c%0d", c),   tr_id[c],   0);
        end

        // Test 2: only requester 2, six beats -> 4-beat burst, bubble, 2 beats.
        do_reset();
        for (int d = 1; d <= 6; d++) push(2, d);
        drive_inputs();
        run(9);
        check_we("t2", 9, 32'b011011110);
        for (int c = 1; c < 8; c++) check_val($sformatf("t2_id_c%0d", c), tr_id[c], 2);
        check_val("t2_nlog", nlog, 6);
        for (int k = 0; k < 6; k++) check_val($sformatf("t2_data_%0d", k), log_data[k], k + 1);

        // Test 3: all valid -> grants 0,1,2,3 then wrap to 0, then 1.
        do_reset();
        for (int d = 1; d <= 8; d++) push(0, d);
        for (int d = 9; d <= 13; d++) push(1, d);
        push(2, 14); push(2, 15); push(2, 0); push(2, 1);
        for (int d = 2; d <= 5; d++) push(3, d);
        drive_inputs();
        run(27);
        check_val("t3_nlog", nlog, 21);
        for (int k = 0; k < 21; k++) begin
            check_val($sformatf("t3_id_%0d", k),   log_id[k],   e3_id[k]);
            check_val($sformatf("t3_data_%0d", k), log_data[k], e3_d[k]);
        end
        for (int c = 0; c <= 25; c += 5) check_val($sformatf("t3_bubble_c%0d", c), tr_we[c], 0);

        // Test 4: requester 1 stalled by fifo_full for 3 cycles after 2 beats.
        do_reset();
        for (int d = 10; d <= 13; d++) push(1, d);
        drive_inputs();
        run(3);
        fifo_full = 1'b1;
        run(3);
        fifo_full = 1'b0;
        run(4);
        check_we("t4", 9, 32'b011000110);
        for (int c = 3; c <= 5; c++) begin
            check_val($sformatf("t4_rdy_c%0d", c),  tr_rdy[c],  0);
            check_val($sformatf("t4_id_c%0d", c),   tr_id[c],   1);
            check_val($sformatf("t4_busy_c%0d", c), tr_busy[c], 1);
        end
        check_val("t4_busy_c8", tr_busy[8], 0);
        check_val("t4_nlog", nlog, 4);
        for (int k = 0; k < 4; k++) check_val($sformatf("t4_data_%0d", k), log_data[k], 10 + k);

        // Test 5: requester 0 drops valid after 2 beats; requester 3 takes over
        // with a fresh 4-beat allowance.
        do_reset();
        push(0, 1); push(0, 2);
        for (int d = 7; d <= 11; d++) push(3, d);
        drive_inputs();
        run(11);
        check_we("t5", 11, 32'b10111100110);
        check_val("t5_busy_c3", tr_busy[3], 1);
        check_val("t5_busy_c4", tr_busy[4], 0);
        check_val("t5_id_c5",   tr_id[5],   3);
        check_val("t5_nlog", nlog, 7);
        for (int k = 0; k < 7; k++) begin
            check_val($sformatf("t5_id_%0d", k),   log_id[k],   e5_id[k]);
            check_val($sformatf("t5_data_%0d", k), log_data[k], e5_d[k]);
        end

        // Test 6: reset pulse during a requester 2 burst with 0 and 2 valid.
        do_reset();
        for (int d = 1; d <= 6; d++) push(2, d);
        drive_inputs();
        run(2);
        for (int d = 8; d <= 11; d++) push(0, d);
        drive_inputs();
        run(1);
        rstN = 1'b0;
        run(1);
        rstN = 1'b1;
        run(8);
        check_we("t6", 12, 32'b110111100110);
        check_val("t6_rdy_c3",  tr_rdy[3],  0);
        check_val("t6_busy_c3", tr_busy[3], 0);
        check_val("t6_busy_c4", tr_busy[4], 0);
        check_val("t6_id_c4",   tr_id[4],   0);
        check_val("t6_id_c5",   tr_id[5],   0);
        check_val("t6_nlog", nlog, 8);
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("t6_id_%0d", k),   log_id[k],   e6_id[k]);
            check_val($sformatf("t6_data_%0d", k), log_data[k], e6_d[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
